// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, nibble width
// and the operand-width legality check.
package nsa_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int WIDTH_MIN = 8;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } nsa_state_t;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder with group propagate/generate outputs.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign pg = &w_p;
    assign gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign s    = w_p ^ w_c;
    assign cout = gg | (pg & cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// Add/subtract WIDTH-bit operands one nibble per cycle, LSB nibble first.
// Define NSA_FLAGS_EN to compute the ovf/zero flags; otherwise they read 0.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if (!width_legal(WIDTH)) begin : g_width_check
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 in 8..64");
        end
    endgenerate

    nsa_state_t        r_state;
    nsa_state_t        w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b_eff;
    logic [WIDTH-1:0]  r_sum;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic              r_cout;

    logic              w_accept;
    logic              w_last;
    logic [NIBBLE_W-1:0] w_a_nibs [NIBBLES];
    logic [NIBBLE_W-1:0] w_b_nibs [NIBBLES];
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic              w_nib_cout;
    logic [WIDTH-1:0]  w_sum_next;
    logic              w_pg_unused;
    logic              w_gg_unused;

    // Nibble slicing and in-place merge of the freshly added nibble.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_a_nibs[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
            assign w_b_nibs[gi] = r_b_eff[gi*NIBBLE_W +: NIBBLE_W];
            assign w_sum_next[gi*NIBBLE_W +: NIBBLE_W] =
                (r_idx == IDX_W'(gi)) ? w_nib_sum : r_sum[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign w_a_nib  = w_a_nibs[r_idx];
    assign w_b_nib  = w_b_nibs[r_idx];
    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);

    cla_4bit u_cla (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .s    (w_nib_sum),
        .cout (w_nib_cout),
        .pg   (w_pg_unused),
        .gg   (w_gg_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so the borrow-in folds into the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b_eff <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b_eff <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_nib_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_nib_cout;
            end
        end
    end

`ifdef NSA_FLAGS_EN
    logic r_ovf;
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_ovf  <= (r_a[WIDTH-1] == r_b_eff[WIDTH-1]) && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
            r_zero <= (w_sum_next == '0);
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
